memory_load_ctrl: RTL
=====================

Name: memory_load_ctrl

Overview:
Host-side load sequencer for the accelerator parameter/input memories. It accepts a region-select command and then a byte stream. It generates auto-incrementing write addresses, data and write enables for the four interleaved image RAM banks, the conv parameter RAM and the dense parameter RAM. It tracks per-region load completion so compute is gated on all memories being filled.

Parameters:
IMAGE_BYTES, 3072, bytes per image load (max 4096 = 4 banks x 1024)
CONV_BYTES, 20000, bytes per conv-parameter load (max 32768)
DENSE_BYTES, 16384, bytes per dense-parameter load (max 32768)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (0 = reset)
cmd_valid  in  1  command strobe
cmd_sel  in  2  region: 0 image, 1 conv, 2 dense, 3 illegal
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
in_valid  in  1  stream byte valid
in_data  in  8  stream byte
in_ready  out  1  byte accepted when in_valid & in_ready
abort  in  1  cancel current load
clear_done  in  1  clear all done flags
image_ram_addr_a  out  10  image bank write address
data_image0..data_image3  out  8 each  image bank write data
we_image0..we_image3  out  1 each  image bank write enables
conv_ram_addr_a  out  15  conv write address
data_conv  out  8  conv write data
we_conv  out  1  conv write enable
dense_ram_addr_a  out  15  dense write address
data_dense  out  8  dense write data
we_dense  out  1  dense write enable
busy  out  1  high outside IDLE
load_done  out  3  sticky per-region done flags [0] image, [1] conv, [2] dense
all_loaded  out  1  &load_done
cmd_err  out  1  one-cycle pulse on illegal cmd_sel

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, beat_cnt=0, load_done=0, cmd_err=0, all we_*=0, all addr/data outputs=0. Reset mid-load abandons the load with no further writes.
- States: IDLE, LOAD_IMG, LOAD_CONV, LOAD_DENSE.
- IDLE: cmd_ready=1, in_ready=0.
  - Command accept with cmd_sel 0/1/2: go to the matching LOAD state, set beat_cnt=0, clear that region's load_done bit.
  - cmd_sel 3: stay IDLE, cmd_err=1 for one cycle.
  - clear_done in IDLE: load_done=0. Ignored outside IDLE.
- LOAD_x: cmd_ready=0, in_ready = !abort (combinational).
- Each accepted beat: beat_cnt increments (15-bit). Exactly one write is issued the following cycle (1-cycle latency, registered), and we_* is high for that single cycle.
- Image mapping, beat k: bank = k[1:0], image_ram_addr_a = k[11:2], data_imageN = in_data for all N. Only we_image{k[1:0]} is asserted (one-hot).
- Conv/dense mapping: addr = k, data = in_data.
- No beat accepted: all we_*=0. Addr/data hold their last values.
- Final beat (k == BYTES-1 for the region): same edge sets the region's load_done bit and returns to IDLE. The final write appears the cycle after, while already in IDLE.
- Stalls: gaps in in_valid are allowed indefinitely. No timeout.
- abort in LOAD_x: the beat in that cycle is not accepted, no write is issued, return to IDLE, and the region's load_done stays 0. Abort wins over a simultaneous final beat. abort in IDLE has no effect.
- Reloading a completed region is allowed: its flag clears at command accept and sets again on completion.
- busy = (state != IDLE). all_loaded = load_done[0] & load_done[1] & load_done[2].
- Parameter values above their maximum are illegal; elaboration must fail via an assertion.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0, cmd_ready=1 afterwards.
- Image load: cmd_sel=0, stream bytes 0x00..0xFF repeating for 3072 beats with no gaps. Beat 5 (0x05) -> we_image1=1, image_ram_addr_a=1, data=0x05, one cycle after acceptance. Beat 3071 -> we_image3, addr 767. Then load_done=3'b001 and busy=0.
- Conv load with in_valid toggling every other cycle: exactly 20000 we_conv pulses, addresses 0..19999 contiguous, load_done[1]=1 only after the last beat.
- Abort at beat 100 of a dense load: no we_dense after the write for beat 99, load_done[2]=0, state IDLE. A new cmd_sel=2 then restarts at addr 0.
- Load all three regions -> all_loaded=1. Then cmd_sel=3 -> one-cycle cmd_err, flags unchanged. Then clear_done -> load_done=0, all_loaded=0.
- Abort asserted together with the final conv beat -> no write for that beat, load_done[1]=0.

Source files
------------

// File: rtl/memory_load_ctrl_if.sv
// Host-side command and byte-stream handshake for the memory load sequencer.
interface memory_load_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_sel;
  logic       cmd_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       abort;
  logic       clear_done;

  modport master (
    output cmd_valid, cmd_sel, in_valid, in_data, abort, clear_done,
    input  cmd_ready, in_ready
  );

  modport slave (
    input  cmd_valid, cmd_sel, in_valid, in_data, abort, clear_done,
    output cmd_ready, in_ready
  );
endinterface

// File: rtl/memory_load_ctrl.sv
// Load sequencer: takes a region command then a byte stream, and emits
// registered, auto-incrementing writes into the interleaved image banks,
// the conv parameter RAM or the dense parameter RAM. Per-region sticky done
// flags gate compute until every memory is filled.
module memory_load_ctrl #(
  parameter int IMAGE_BYTES = 3072,
  parameter int CONV_BYTES  = 20000,
  parameter int DENSE_BYTES = 16384
) (
  input  logic                     clk,
  input  logic                     reset,
  memory_load_ctrl_if.slave        host,
  output logic [9:0]               image_ram_addr_a,
  output logic [7:0]               data_image0,
  output logic [7:0]               data_image1,
  output logic [7:0]               data_image2,
  output logic [7:0]               data_image3,
  output logic                     we_image0,
  output logic                     we_image1,
  output logic                     we_image2,
  output logic                     we_image3,
  output logic [14:0]              conv_ram_addr_a,
  output logic [7:0]               data_conv,
  output logic                     we_conv,
  output logic [14:0]              dense_ram_addr_a,
  output logic [7:0]               data_dense,
  output logic                     we_dense,
  output logic                     busy,
  output logic [2:0]               load_done,
  output logic                     all_loaded,
  output logic                     cmd_err
);

  // Oversized loads cannot be addressed by the target RAMs.
  if (IMAGE_BYTES < 1 || IMAGE_BYTES > 4096) begin : g_bad_image_bytes
    $fatal(1, "IMAGE_BYTES out of range 1..4096");
  end
  if (CONV_BYTES < 1 || CONV_BYTES > 32768) begin : g_bad_conv_bytes
    $fatal(1, "CONV_BYTES out of range 1..32768");
  end
  if (DENSE_BYTES < 1 || DENSE_BYTES > 32768) begin : g_bad_dense_bytes
    $fatal(1, "DENSE_BYTES out of range 1..32768");
  end

  localparam logic [14:0] IMG_LAST   = 15'(IMAGE_BYTES - 1);
  localparam logic [14:0] CONV_LAST  = 15'(CONV_BYTES - 1);
  localparam logic [14:0] DENSE_LAST = 15'(DENSE_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_IMG   = 2'd1,
    LOAD_CONV  = 2'd2,
    LOAD_DENSE = 2'd3
  } state_t;

  state_t      state;
  logic [14:0] beat_cnt;
  logic [3:0]  we_img;
  logic [7:0]  img_data;

  assign busy           = (state != IDLE);
  assign host.cmd_ready = (state == IDLE);
  assign host.in_ready  = busy & ~host.abort;
  assign all_loaded     = &load_done;

  // All four banks see the same byte; only the one-hot enable picks the bank.
  assign data_image0 = img_data;
  assign data_image1 = img_data;
  assign data_image2 = img_data;
  assign data_image3 = img_data;
  assign we_image0   = we_img[0];
  assign we_image1   = we_img[1];
  assign we_image2   = we_img[2];
  assign we_image3   = we_img[3];

  // Command decode, beat counting and registered write generation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      beat_cnt         <= '0;
      load_done        <= '0;
      cmd_err          <= 1'b0;
      we_img           <= '0;
      img_data         <= '0;
      image_ram_addr_a <= '0;
      we_conv          <= 1'b0;
      data_conv        <= '0;
      conv_ram_addr_a  <= '0;
      we_dense         <= 1'b0;
      data_dense       <= '0;
      dense_ram_addr_a <= '0;
    end else begin
      we_img   <= '0;
      we_conv  <= 1'b0;
      we_dense <= 1'b0;
      cmd_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          // A region's own clear below overrides nothing else; clear_done only
          // acts here so a running load cannot lose its neighbours' flags.
          if (host.clear_done) load_done <= '0;
          if (host.cmd_valid) begin
            unique case (host.cmd_sel)
              2'd0: begin
                state        <= LOAD_IMG;
                beat_cnt     <= '0;
                load_done[0] <= 1'b0;
              end
              2'd1: begin
                state        <= LOAD_CONV;
                beat_cnt     <= '0;
                load_done[1] <= 1'b0;
              end
              2'd2: begin
                state        <= LOAD_DENSE;
                beat_cnt     <= '0;
                load_done[2] <= 1'b0;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
        end
        LOAD_IMG: begin
          if (host.abort) begin
            state <= IDLE;
          end else if (host.in_valid) begin
            image_ram_addr_a <= beat_cnt[11:2];
            img_data         <= host.in_data;
            we_img           <= 4'b0001 << beat_cnt[1:0];
            beat_cnt         <= beat_cnt + 15'd1;
            if (beat_cnt == IMG_LAST) begin
              load_done[0] <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        LOAD_CONV: begin
          if (host.abort) begin
            state <= IDLE;
          end else if (host.in_valid) begin
            conv_ram_addr_a <= beat_cnt;
            data_conv       <= host.in_data;
            we_conv         <= 1'b1;
            beat_cnt        <= beat_cnt + 15'd1;
            if (beat_cnt == CONV_LAST) begin
              load_done[1] <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        LOAD_DENSE: begin
          if (host.abort) begin
            state <= IDLE;
          end else if (host.in_valid) begin
            dense_ram_addr_a <= beat_cnt;
            data_dense       <= host.in_data;
            we_dense         <= 1'b1;
            beat_cnt         <= beat_cnt + 15'd1;
            if (beat_cnt == DENSE_LAST) begin
              load_done[2] <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
